d_ff: RTL and testbench
=======================

# d_ff

Single-bit (width-parameterisable) positive-edge D-type register with synchronous, active-high reset. It is the basic storage primitive for registering data paths and control bits on a single clock domain. It can be used alone or as the leaf cell of wider pipeline registers. It has no enable and no handshake: a sample is taken on every rising clock edge.

## Interface

Clock and reset: one clock, `clk`. Reset is `reset`, synchronous and active-high.

Parameters:
- `WIDTH`, default 1: bit width of `d` and `q`.
- `RESET_VALUE`, default all zeros (`{WIDTH{1'b0}}`): value loaded into `q` on reset.

Ports:
- `clk`  input  1  rising-edge sampling clock.
- `reset`  input  1  synchronous reset, active-high; sampled only on the `clk` rising edge.
- `d`  input  WIDTH  data input.
- `q`  output  WIDTH  registered output, driven directly from the storage element with no combinational path from `d` or `reset`.

## Operation

- At each `clk` rising edge:
  - if `reset` = 1, then `q` <= `RESET_VALUE`;
  - else `q` <= `d`.
- `reset` has priority over `d` at the same edge.
- Between rising edges, `q` holds its value regardless of activity on `d` or `reset`.
- Falling edges of `clk` have no effect.
- No internal state other than `q`. No state machine and no arithmetic.
- Bit-wise independence: each bit of `q` follows the same rule on its own bit of `d`.
- Power-up: `q` is undefined (X in simulation) until the first rising edge with `reset` = 1, or the first rising edge that samples a known `d`. No initial value is imposed in RTL.

## Timing

- Latency: 1 cycle. A value on `d` at rising edge N appears on `q` just after edge N and is held until edge N+1.
- Reset takes effect at the first rising edge where `reset` = 1. `q` = `RESET_VALUE` just after that edge.
- Reset release: at the first rising edge with `reset` = 0, `q` <= `d`.
- A reset pulse that begins and ends between two rising edges is ignored. This includes pulses that are low-going or high-going mid-cycle.
- Changes of `d` between edges are ignored. Only the value present at the edge, within setup/hold, is captured.
- `d` and `reset` must meet setup/hold relative to the `clk` rising edge. There are no asynchronous paths.
- Simultaneous change of `reset` and `d` before the same edge: `reset` wins if it is 1 at the edge.

## Test plan

- Clock period 100 ns (toggle every 50 ns). `d`=1 and `reset`=1 held through the 50 ns edge -> `q`=0 after 50 ns. Then `reset`=0 with `d`=1 before the 150 ns edge -> `q`=1 after 150 ns.
- Reset mid-cycle glitch: with `reset`=0 and `q`=1, pulse `reset`=1 for 10 ns and release it before the next rising edge -> `q` stays 1, with no change between edges or at the edge.
- Data glitch: with `reset`=0, toggle `d` 1->0->1 entirely between two rising edges -> `q` captures only the value at the edge (1). No intermediate change is visible on `q`.
- Priority: drive `reset`=1 and `d`=1 together at an edge while `q`=1 -> `q`=0 after that edge. Drop `reset` with `d`=1 -> `q`=1 one edge later.
- Stream: `reset`=0, apply `d` = 1,0,1,1,0 on successive edges -> `q` shows the same sequence delayed by exactly one cycle.
- Parameterised instance: `WIDTH`=8, `RESET_VALUE`=8'hA5.
  - Reset edge -> `q`=8'hA5.
  - Then `d`=8'h3C with `reset`=0 -> `q`=8'h3C after the next edge.

Source files
------------

// File: rtl/d_ff.sv
// d_ff: positive-edge D register, synchronous active-high reset.
// Width and reset value are parameters; q comes straight from the flops.
module d_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else       q <= d;
  end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed and random checks of d_ff at WIDTH=1 and WIDTH=8.
// Expected q is the rule "reset ? RESET_VALUE : d" delivered one edge later.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst1, rst8;
  logic [0:0] d1, q1;
  logic [7:0] d8, q8;

  int checks   = 0;
  int failures = 0;

  logic [0:0] x1[$];
  logic [7:0] x8[$];
  logic [0:0] h1;
  logic [7:0] h8;
  logic [4:0] pat;

  always #50 clk = ~clk;

  d_ff u1 (
    .clk  (clk),
    .reset(rst1),
    .d    (d1),
    .q    (q1)
  );

  d_ff #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) u8 (
    .clk  (clk),
    .reset(rst8),
    .d    (d8),
    .q    (q8)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic v1,
                       input logic r8, input logic [7:0] v8);
    rst1 = r1;
    d1   = v1;
    rst8 = r8;
    d8   = v8;
    x1.push_back(r1 ? 1'b0 : v1);
    x8.push_back(r8 ? 8'hA5 : v8);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    h1 = x1.pop_front();
    h8 = x8.pop_front();
    chk({tag, "_q1"}, {7'b0, q1}, {7'b0, h1});
    chk({tag, "_q8"}, q8, h8);
  endtask

  task automatic hold(input string tag);
    chk({tag, "_q1"}, {7'b0, q1}, {7'b0, h1});
    chk({tag, "_q8"}, q8, h8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b1, 1'b1, 8'($urandom));
    tick("reset");

    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    tick("release");

    @(negedge clk);
    rst1 = 1'b1;
    rst8 = 1'b1;
    #10;
    rst1 = 1'b0;
    rst8 = 1'b0;
    #5;
    hold("rst_glitch_mid");
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    tick("rst_glitch_edge");

    @(negedge clk);
    d1 = 1'b0;
    d8 = 8'h00;
    #10;
    hold("d_glitch_mid");
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    tick("d_glitch_edge");

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick("d_low");
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'hFF;
    #10;
    hold("d_glitch0_mid");
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick("d_glitch0_edge");

    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    tick("prio_pre");
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    tick("prio");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    tick("prio_rel");

    pat = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      drive(1'b0, pat[i], 1'b0, 8'($urandom));
      tick("stream");
    end

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hold("fall_hold");
      drive(($urandom % 4) == 0, 1'($urandom),
            ($urandom % 4) == 0, 8'($urandom));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
